execute_block: RTL

//  EX stage of the 16-bit MIPS pipeline. Takes decoded operands and control from ID, computes the ALU result,
//  and registers it with memory/writeback control into the EX/DM pipeline register that feeds Data_Memory_Block.
//  MUL is iterative (16 cycles, shift-add) and stalls upstream through a stall handshake; other ops take 1 cycle.

---
 rtl/execute_block_pkg.sv | 31 +++
 rtl/execute_block_mul_seq.sv | 80 ++++++++
 rtl/execute_block.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/execute_block_pkg.sv
// Shared definitions for the EX stage of the 16-bit MIPS pipeline:
// datapath defaults, ALU operation codes and multiplier FSM states.
package execute_block_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_RADDR_W = 3;

    // Codes 13-15 are reserved and produce a zero result.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLL  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_SLT  = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_PASS = 4'd11,
        ALU_MUL  = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/execute_block_mul_seq.sv
// Iterative shift-add multiplier producing the low WIDTH bits of A*B.
// One partial product per BUSY cycle, then a single DONE cycle in which
// the product is presented to the EX/DM register.
module execute_block_mul_seq
    import execute_block_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             idle,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_e       state;
    mul_state_e       state_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             load;

    assign load = (state == MUL_IDLE) && start && !flush;

    // State register; reset drops any multiply in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= MUL_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            MUL_IDLE: if (load) state_next = MUL_BUSY;
            MUL_BUSY: begin
                if (flush)                state_next = MUL_IDLE;
                else if (cnt == LAST_CNT) state_next = MUL_DONE;
            end
            MUL_DONE: state_next = MUL_IDLE;
            default:  state_next = MUL_IDLE;
        endcase
    end

    // Operand latch on start, then one shift-add step per BUSY cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == MUL_BUSY && !flush) begin
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    assign idle    = (state == MUL_IDLE);
    assign busy    = (state == MUL_BUSY);
    assign done    = (state == MUL_DONE);
    assign product = acc;

endmodule

// File: rtl/execute_block.sv
// EX stage: single-cycle ALU with flags, iterative MUL with upstream stall,
// and the EX/DM pipeline register feeding the data memory block.
module execute_block
    import execute_block_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int RADDR_W = DEF_RADDR_W
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_id,
    input  logic [3:0]         alu_op_id,
    input  logic [WIDTH-1:0]   op_a_id,
    input  logic [WIDTH-1:0]   op_b_id,
    input  logic [WIDTH-1:0]   imm_id,
    input  logic               alu_src_id,
    input  logic [WIDTH-1:0]   st_data_id,
    input  logic               mem_rw_id,
    input  logic               mem_en_id,
    input  logic               mem_mux_sel_id,
    input  logic               reg_wr_id,
    input  logic [RADDR_W-1:0] rd_id,
    input  logic               flush,
    output logic [WIDTH-1:0]   ans_ex,
    output logic [WIDTH-1:0]   DM_data,
    output logic               mem_rw_ex,
    output logic               mem_en_ex,
    output logic               mem_mux_sel_ex,
    output logic               reg_wr_ex,
    output logic [RADDR_W-1:0] rd_ex,
    output logic               valid_ex,
    output logic               zero_ex,
    output logic               carry_ex,
    output logic               ovf_ex,
    output logic               stall
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   op_b_sel;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_carry;
    logic               alu_ovf;
    logic               is_mul;
    logic               mul_idle;
    logic               mul_busy;
    logic               mul_done;
    logic [WIDTH-1:0]   mul_product;
    logic               take_mul;
    logic               take_alu;

    assign op_b_sel = alu_src_id ? imm_id : op_b_id;
    assign shamt    = op_b_sel[SHAMT_W-1:0];
    assign sum_ext  = {1'b0, op_a_id} + {1'b0, op_b_sel};
    assign diff     = op_a_id - op_b_sel;
    assign is_mul   = (alu_op_id == ALU_MUL);

    execute_block_mul_seq #(.WIDTH(WIDTH)) u_mul_seq (
        .clk     (clk),
        .reset   (reset),
        .start   (valid_id && is_mul),
        .flush   (flush),
        .op_a    (op_a_id),
        .op_b    (op_b_sel),
        .idle    (mul_idle),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // ID holds while a MUL is being accepted or iterating; never during reset.
    assign stall = reset && ((mul_idle && valid_id && is_mul) || mul_busy);

    // Flush kills whatever would have entered EX/DM this edge.
    assign take_mul = mul_done && !flush;
    assign take_alu = valid_id && !is_mul && mul_idle && !flush;

    // Single-cycle ALU result with carry/overflow for ADD and SUB only.
    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        alu_ovf    = 1'b0;
        case (alu_op_id)
            ALU_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                alu_carry  = sum_ext[WIDTH];
                alu_ovf    = (op_a_id[WIDTH-1] == op_b_sel[WIDTH-1]) &&
                             (sum_ext[WIDTH-1] != op_a_id[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_result = diff;
                alu_carry  = (op_a_id >= op_b_sel);
                alu_ovf    = (op_a_id[WIDTH-1] != op_b_sel[WIDTH-1]) &&
                             (diff[WIDTH-1] != op_a_id[WIDTH-1]);
            end
            ALU_AND:  alu_result = op_a_id & op_b_sel;
            ALU_OR:   alu_result = op_a_id | op_b_sel;
            ALU_XOR:  alu_result = op_a_id ^ op_b_sel;
            ALU_NOR:  alu_result = ~(op_a_id | op_b_sel);
            ALU_SLL:  alu_result = op_a_id << shamt;
            ALU_SRL:  alu_result = op_a_id >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(op_a_id) >>> shamt);
            ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(op_a_id) < $signed(op_b_sel))};
            ALU_LUI:  alu_result = op_b_sel << 8;
            ALU_PASS: alu_result = op_a_id;
            default:  alu_result = '0;
        endcase
    end

    // EX/DM register: MUL product on DONE, ALU result on a plain op, else a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ans_ex         <= '0;
            DM_data        <= '0;
            mem_rw_ex      <= 1'b0;
            mem_en_ex      <= 1'b0;
            mem_mux_sel_ex <= 1'b0;
            reg_wr_ex      <= 1'b0;
            rd_ex          <= '0;
            valid_ex       <= 1'b0;
            zero_ex        <= 1'b0;
            carry_ex       <= 1'b0;
            ovf_ex         <= 1'b0;
        end else if (take_mul) begin
            ans_ex         <= mul_product;
            DM_data        <= st_data_id;
            mem_rw_ex      <= mem_rw_id;
            mem_en_ex      <= mem_en_id;
            mem_mux_sel_ex <= mem_mux_sel_id;
            reg_wr_ex      <= reg_wr_id;
            rd_ex          <= rd_id;
            valid_ex       <= 1'b1;
            zero_ex        <= (mul_product == '0);
            carry_ex       <= 1'b0;
            ovf_ex         <= 1'b0;
        end else if (take_alu) begin
            ans_ex         <= alu_result;
            DM_data        <= st_data_id;
            mem_rw_ex      <= mem_rw_id;
            mem_en_ex      <= mem_en_id;
            mem_mux_sel_ex <= mem_mux_sel_id;
            reg_wr_ex      <= reg_wr_id;
            rd_ex          <= rd_id;
            valid_ex       <= 1'b1;
            zero_ex        <= (alu_result == '0);
            carry_ex       <= alu_carry;
            ovf_ex         <= alu_ovf;
        end else begin
            valid_ex       <= 1'b0;
            mem_rw_ex      <= 1'b0;
            mem_en_ex      <= 1'b0;
            reg_wr_ex      <= 1'b0;
        end
    end

endmodule
